// File: rtl/ysyx_23060191_wb_regfile.sv
// Writeback sink: commits GPR/CSR writes and ecall/mret side effects, serves
// combinational register/CSR reads and raises a registered commit pulse.
module ysyx_23060191_wb_regfile #(
  parameter int unsigned CPU_WIDTH  = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic                  wb_rd_wen,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic [CPU_WIDTH-1:0]  wb_rd_data,
  input  logic                  wb_csr_wen,
  input  logic [11:0]           wb_csr_addr,
  input  logic [CPU_WIDTH-1:0]  wb_csr_data,
  input  logic                  wb_ecall,
  input  logic                  wb_mret,
  input  logic [CPU_WIDTH-1:0]  wb_pc,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [CPU_WIDTH-1:0]  rs1_data,
  output logic [CPU_WIDTH-1:0]  rs2_data,
  input  logic [11:0]           csr_raddr,
  output logic [CPU_WIDTH-1:0]  csr_rdata,
  output logic [CPU_WIDTH-1:0]  mtvec_o,
  output logic [CPU_WIDTH-1:0]  mepc_o,
  output logic                  wb_done,
  output logic [CPU_WIDTH-1:0]  wb_done_pc
);

  localparam int unsigned NUM_REGS    = 32'(1) << REG_ADDR_W;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [CPU_WIDTH-1:0] MSTATUS_RST = CPU_WIDTH'(32'h0000_1800);
  localparam logic [CPU_WIDTH-1:0] CAUSE_ECALL = CPU_WIDTH'(11);

  typedef enum logic {IDLE, COMMIT} state_t;

  state_t                r_state;
  logic                  r_ready;
  logic                  r_done;
  logic [CPU_WIDTH-1:0]  r_done_pc;
  logic [CPU_WIDTH-1:0]  r_gpr [0:NUM_REGS-1];
  logic [CPU_WIDTH-1:0]  r_mstatus;
  logic [CPU_WIDTH-1:0]  r_mtvec;
  logic [CPU_WIDTH-1:0]  r_mepc;
  logic [CPU_WIDTH-1:0]  r_mcause;

  logic                  w_hs;
  logic                  w_rd_we;
  logic                  w_csr_we;
  logic [CPU_WIDTH-1:0]  w_mstatus_nxt;
  logic [CPU_WIDTH-1:0]  w_mtvec_nxt;
  logic [CPU_WIDTH-1:0]  w_mepc_nxt;
  logic [CPU_WIDTH-1:0]  w_mcause_nxt;
  logic [CPU_WIDTH-1:0]  w_rs1;
  logic [CPU_WIDTH-1:0]  w_rs2;
  logic [CPU_WIDTH-1:0]  w_csr_rd;

  assign w_hs     = wb_valid & r_ready;
  assign w_rd_we  = w_hs & wb_rd_wen & (wb_rd_addr != '0);
  assign w_csr_we = w_hs & wb_csr_wen;

  // CSR next values: software write first, trap side effects override conflicting fields
  always_comb begin
    w_mstatus_nxt = r_mstatus;
    w_mtvec_nxt   = r_mtvec;
    w_mepc_nxt    = r_mepc;
    w_mcause_nxt  = r_mcause;
    if (w_csr_we) begin
      case (wb_csr_addr)
        CSR_MSTATUS: w_mstatus_nxt = wb_csr_data;
        CSR_MTVEC:   w_mtvec_nxt   = wb_csr_data;
        CSR_MEPC:    w_mepc_nxt    = wb_csr_data;
        CSR_MCAUSE:  w_mcause_nxt  = wb_csr_data;
        default: ;
      endcase
    end
    if (wb_ecall) begin
      w_mepc_nxt            = wb_pc;
      w_mcause_nxt          = CAUSE_ECALL;
      w_mstatus_nxt[7]      = r_mstatus[3];
      w_mstatus_nxt[3]      = 1'b0;
      w_mstatus_nxt[12:11]  = 2'b11;
    end else if (wb_mret) begin
      w_mstatus_nxt[3]      = r_mstatus[7];
      w_mstatus_nxt[7]      = 1'b1;
      w_mstatus_nxt[12:11]  = 2'b11;
    end
  end

  // GPR read ports with same-cycle forwarding of the accepted write
  always_comb begin
    w_rs1 = '0;
    w_rs2 = '0;
    if (rs1_addr != '0)
      w_rs1 = (w_rd_we && (wb_rd_addr == rs1_addr)) ? wb_rd_data : r_gpr[rs1_addr];
    if (rs2_addr != '0)
      w_rs2 = (w_rd_we && (wb_rd_addr == rs2_addr)) ? wb_rd_data : r_gpr[rs2_addr];
  end

  always_comb begin
    w_csr_rd = '0;
    case (csr_raddr)
      CSR_MSTATUS: w_csr_rd = r_mstatus;
      CSR_MTVEC:   w_csr_rd = r_mtvec;
      CSR_MEPC:    w_csr_rd = r_mepc;
      CSR_MCAUSE:  w_csr_rd = r_mcause;
      default:     w_csr_rd = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_done_pc <= '0;
      r_mstatus <= MSTATUS_RST;
      r_mtvec   <= '0;
      r_mepc    <= '0;
      r_mcause  <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_gpr[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_state   <= COMMIT;
            r_ready   <= 1'b0;
            r_done    <= 1'b1;
            r_done_pc <= wb_pc;
            r_mstatus <= w_mstatus_nxt;
            r_mtvec   <= w_mtvec_nxt;
            r_mepc    <= w_mepc_nxt;
            r_mcause  <= w_mcause_nxt;
            if (w_rd_we) r_gpr[wb_rd_addr] <= wb_rd_data;
          end
        end
        COMMIT: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign wb_ready   = r_ready;
  assign wb_done    = r_done;
  assign wb_done_pc = r_done_pc;
  assign rs1_data   = w_rs1;
  assign rs2_data   = w_rs2;
  assign csr_rdata  = w_csr_rd;
  assign mtvec_o    = r_mtvec;
  assign mepc_o     = r_mepc;

endmodule

// File: tb/tb_ysyx_23060191_wb_regfile.sv
// Self-checking bench for the writeback register file: directed cases plus
// random transactions against an array/variable reference model.
module tb_ysyx_23060191_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, wb_ready, wb_rd_wen, wb_csr_wen, wb_ecall, wb_mret, wb_done;
  logic [4:0]  wb_rd_addr, rs1_addr, rs2_addr;
  logic [11:0] wb_csr_addr, csr_raddr;
  logic [31:0] wb_rd_data, wb_csr_data, wb_pc, rs1_data, rs2_data, csr_rdata;
  logic [31:0] mtvec_o, mepc_o, wb_done_pc;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_gpr [32];
  logic [31:0] m_ms, m_mtvec, m_mepc, m_mcause;

  ysyx_23060191_wb_regfile #(.CPU_WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd_wen(wb_rd_wen), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .wb_csr_wen(wb_csr_wen), .wb_csr_addr(wb_csr_addr), .wb_csr_data(wb_csr_data),
    .wb_ecall(wb_ecall), .wb_mret(wb_mret), .wb_pc(wb_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o),
    .wb_done(wb_done), .wb_done_pc(wb_done_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_csr(input logic [11:0] a);
    case (a)
      12'h300: return m_ms;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
    m_ms = 32'h1800; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
  endtask

  // Reference commit: software CSR write, then trap fields take priority
  task automatic m_commit(input logic rwe, input logic [4:0] rd, input logic [31:0] rdat,
                          input logic cwe, input logic [11:0] ca, input logic [31:0] cdat,
                          input logic ec, input logic mr, input logic [31:0] pc);
    logic [31:0] old_ms;
    old_ms = m_ms;
    if (rwe && rd != 0) m_gpr[rd] = rdat;
    if (cwe) begin
      if (ca == 12'h300) m_ms = cdat;
      if (ca == 12'h305) m_mtvec = cdat;
      if (ca == 12'h341) m_mepc = cdat;
      if (ca == 12'h342) m_mcause = cdat;
    end
    if (ec) begin
      m_mepc = pc;
      m_mcause = 11;
      m_ms = (m_ms & ~32'h1888) | 32'h1800 | ((old_ms & 32'h8) << 4);
    end else if (mr) begin
      m_ms = (m_ms & ~32'h1888) | 32'h1880 | ((old_ms >> 4) & 32'h8);
    end
  endtask

  task automatic peek(input string tag, input logic [4:0] r, input logic [11:0] ca);
    rs1_addr = r; rs2_addr = r; csr_raddr = ca;
    #1;
    chk({tag, "_rs1"}, rs1_data, m_gpr[r]);
    chk({tag, "_csr"}, csr_rdata, m_csr(ca));
  endtask

  // One transaction: forwarding check before the edge, commit checks after,
  // optional spurious valid in COMMIT, optional reset during COMMIT.
  task automatic xact(input string tag,
                      input logic rwe, input logic [4:0] rd, input logic [31:0] rdat,
                      input logic cwe, input logic [11:0] ca, input logic [31:0] cdat,
                      input logic ec, input logic mr, input logic [31:0] pc,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [11:0] cr,
                      input logic hold, input logic rst_commit);
    logic [31:0] e1, e2;
    @(negedge clk);
    wb_valid = 1; wb_rd_wen = rwe; wb_rd_addr = rd; wb_rd_data = rdat;
    wb_csr_wen = cwe; wb_csr_addr = ca; wb_csr_data = cdat;
    wb_ecall = ec; wb_mret = mr; wb_pc = pc;
    rs1_addr = r1; rs2_addr = r2; csr_raddr = cr;
    e1 = (r1 == 0) ? 32'h0 : (rwe && rd != 0 && rd == r1) ? rdat : m_gpr[r1];
    e2 = (r2 == 0) ? 32'h0 : (rwe && rd != 0 && rd == r2) ? rdat : m_gpr[r2];
    #1;
    chk({tag, "_ready_pre"}, 32'(wb_ready), 32'h1);
    chk({tag, "_fwd_rs1"}, rs1_data, e1);
    chk({tag, "_fwd_rs2"}, rs2_data, e2);
    chk({tag, "_csr_old"}, csr_rdata, m_csr(cr));
    @(posedge clk); #1;
    m_commit(rwe, rd, rdat, cwe, ca, cdat, ec, mr, pc);
    if (hold) begin
      wb_rd_wen = 1; wb_rd_addr = 5'd7; wb_rd_data = 32'hBAD0_BAD0; wb_csr_wen = 0;
      wb_ecall = 0; wb_mret = 0;
    end else wb_valid = 0;
    #1;
    chk({tag, "_done"}, 32'(wb_done), 32'h1);
    chk({tag, "_ready_commit"}, 32'(wb_ready), 32'h0);
    chk({tag, "_done_pc"}, wb_done_pc, pc);
    chk({tag, "_mtvec_o"}, mtvec_o, m_mtvec);
    chk({tag, "_mepc_o"}, mepc_o, m_mepc);
    chk({tag, "_rs1_after"}, rs1_data, m_gpr[r1]);
    chk({tag, "_csr_new"}, csr_rdata, m_csr(cr));
    if (rst_commit) begin
      wb_valid = 0;
      rst = 1;
      #1;
      m_reset();
      chk({tag, "_rst_done"}, 32'(wb_done), 32'h0);
      chk({tag, "_rst_mtvec"}, mtvec_o, 32'h0);
      chk({tag, "_rst_mepc"}, mepc_o, 32'h0);
      foreach (m_gpr[i]) begin end
      for (int k = 0; k < 4; k++) begin
        logic [11:0] a;
        a = (k == 0) ? 12'h300 : (k == 1) ? 12'h305 : (k == 2) ? 12'h341 : 12'h342;
        csr_raddr = a; #1;
        chk({tag, "_rst_csr"}, csr_rdata, m_csr(a));
      end
      @(negedge clk); rst = 0;
      @(posedge clk); #1;
      chk({tag, "_rst_nodone"}, 32'(wb_done), 32'h0);
      chk({tag, "_rst_ready"}, 32'(wb_ready), 32'h1);
      return;
    end
    @(posedge clk); #1;
    if (hold) wb_valid = 0;
    chk({tag, "_done_clr"}, 32'(wb_done), 32'h0);
    chk({tag, "_ready_back"}, 32'(wb_ready), 32'h1);
  endtask

  initial begin
    logic [11:0] caddrs [6];
    caddrs[0] = 12'h300; caddrs[1] = 12'h305; caddrs[2] = 12'h341;
    caddrs[3] = 12'h342; caddrs[4] = 12'h340; caddrs[5] = 12'h7C0;
    rst = 1; wb_valid = 0; wb_rd_wen = 0; wb_rd_addr = 0; wb_rd_data = 0;
    wb_csr_wen = 0; wb_csr_addr = 0; wb_csr_data = 0; wb_ecall = 0; wb_mret = 0;
    wb_pc = 0; rs1_addr = 0; rs2_addr = 0; csr_raddr = 12'h300;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0;
    #1;
    chk("rst_ready", 32'(wb_ready), 32'h1);
    chk("rst_done", 32'(wb_done), 32'h0);
    chk("rst_done_pc", wb_done_pc, 32'h0);
    chk("rst_mstatus", csr_rdata, 32'h0000_1800);
    for (int i = 1; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(32 - i); #1;
      chk("rst_rs1", rs1_data, 32'h0);
      chk("rst_rs2", rs2_data, 32'h0);
    end

    xact("fwd", 1, 5, 32'hDEAD_BEEF, 0, 12'h0, 0, 0, 0, 32'h8000_0000, 5, 5, 12'h300, 0, 0);
    chk("fwd_array", m_gpr[5], 32'hDEAD_BEEF);
    peek("fwd_peek", 5, 12'h305);

    xact("x0", 1, 0, 32'h1234, 0, 12'h0, 0, 0, 0, 32'h8000_0004, 0, 5, 12'h300, 0, 0);
    peek("x0_peek", 0, 12'h300);

    xact("csrrw", 1, 3, 32'h11, 1, 12'h305, 32'h8000_0100, 0, 0, 32'h8000_0008, 3, 0, 12'h305, 0, 0);
    chk("csrrw_mtvec_o", mtvec_o, 32'h8000_0100);
    peek("csrrw_peek", 3, 12'h305);

    xact("set_ms", 0, 0, 0, 1, 12'h300, 32'h1808, 0, 0, 32'h8000_000C, 1, 2, 12'h300, 0, 0);
    xact("ecall", 0, 0, 0, 0, 12'h0, 0, 1, 0, 32'h8000_0040, 1, 2, 12'h300, 0, 0);
    csr_raddr = 12'h300; #1; chk("ecall_mstatus", csr_rdata, 32'h1880);
    csr_raddr = 12'h341; #1; chk("ecall_mepc", csr_rdata, 32'h8000_0040);
    csr_raddr = 12'h342; #1; chk("ecall_mcause", csr_rdata, 32'd11);
    xact("mret", 0, 0, 0, 0, 12'h0, 0, 0, 1, 32'h8000_0044, 1, 2, 12'h300, 0, 0);
    csr_raddr = 12'h300; #1; chk("mret_mstatus", csr_rdata, 32'h1888);

    xact("hold", 1, 9, 32'hCAFE, 0, 12'h0, 0, 0, 0, 32'h8000_0050, 9, 7, 12'h300, 1, 0);
    peek("hold_x7", 7, 12'h342);
    chk("hold_x7_const", rs1_data, 32'h0);

    for (int n = 0; n < 60; n++) begin
      logic        rwe, cwe, ec, mr;
      logic [4:0]  rd, r1, r2;
      logic [11:0] ca, cr;
      rwe = 1'($urandom_range(0, 1));
      rd  = 5'($urandom_range(0, 31));
      cwe = 1'($urandom_range(0, 1));
      ca  = caddrs[$urandom_range(0, 5)];
      cr  = caddrs[$urandom_range(0, 5)];
      ec  = ($urandom_range(0, 7) == 0);
      mr  = ($urandom_range(0, 5) == 0);
      r1  = ($urandom_range(0, 1) == 1) ? rd : 5'($urandom_range(0, 31));
      r2  = 5'($urandom_range(0, 31));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      xact("rnd", rwe, rd, $urandom, cwe, ca, $urandom, ec, mr, $urandom, r1, r2, cr, 0, 0);
    end

    xact("ec_rst", 0, 0, 0, 1, 12'h341, 32'h0, 1, 0, 32'h8000_0010, 3, 5, 12'h341, 0, 1);
    peek("post_rst", 3, 12'h300);
    chk("post_rst_mstatus", csr_rdata, 32'h0000_1800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
